pc_update_unit: RTL

Program-counter stage fed by the branch decision unit. It holds the architectural PC and accepts one update request at a time from the control FSM: sequential, conditional branch (qualified by the branch-taken decision), jump, or register jump. It computes the target, commits it to the PC over a fixed two-cycle sequence, and reports completion. It sits between the branch decision logic and the instruction-fetch address path.

---
 rtl/pc_update_pkg.sv | 19 +
 rtl/pc_target_calc.sv | 43 ++++
 rtl/pc_update_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pc_update_pkg.sv
// Shared types and constants for the program-counter update stage.
package pc_update_pkg;

   typedef enum logic [1:0] {
      KIND_SEQ    = 2'd0,
      KIND_BRANCH = 2'd1,
      KIND_JUMP   = 2'd2,
      KIND_JR     = 2'd3
   } req_kind_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC   = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC computation from the captured request operands and the old PC.
module pc_target_calc
   import pc_update_pkg::*;
(
   input  req_kind_e   kind,
   input  logic        taken,
   input  logic [15:0] imm16,
   input  logic [25:0] jaddr26,
   input  logic [31:0] reg_target,
   input  logic [31:0] pc,
   output logic [31:0] target,
   output logic        misalign,
   output logic        redirect
);

   logic [31:0] pc4;
   logic [31:0] branch_off;

   assign pc4        = pc + PC_STEP;
   assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

   // A rejected JR leaves the PC where it is, so the target falls back to the old PC.
   always_comb begin
      target   = pc4;
      misalign = 1'b0;
      unique case (kind)
         KIND_SEQ:    target = pc4;
         KIND_BRANCH: target = taken ? (pc4 + branch_off) : pc4;
         KIND_JUMP:   target = {pc4[31:28], jaddr26, 2'b00};
         KIND_JR: begin
            if (reg_target[1:0] != 2'b00) begin
               misalign = 1'b1;
               target   = pc;
            end else begin
               target   = reg_target;
            end
         end
         default:     target = pc4;
      endcase
      redirect = !misalign && (target != pc4);
   end

endmodule

// File: rtl/pc_update_unit.sv
// Architectural PC holder: accepts one update request, computes the target, commits it two edges later.
// Optional branch statistics counters are enabled with `define PC_BRANCH_STATS_EN.
module pc_update_unit
   import pc_update_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          STAT_W   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_kind,
   input  logic        branch_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] jaddr26,
   input  logic [31:0] reg_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        done,
   output logic        redirect,
   output logic        misalign_err
`ifdef PC_BRANCH_STATS_EN
   ,
   output logic [STAT_W-1:0] taken_cnt,
   output logic [STAT_W-1:0] not_taken_cnt
`endif
);

   state_e      state;
   req_kind_e   cap_kind;
   logic        cap_taken;
   logic [15:0] cap_imm;
   logic [25:0] cap_jaddr;
   logic [31:0] cap_reg;

   logic [31:0] calc_target;
   logic        calc_misalign;
   logic        calc_redirect;
   logic [31:0] tgt_q;
   logic        misalign_q;
   logic        redirect_q;

   assign pc_plus4  = pc + PC_STEP;
   assign req_ready = (state == ST_IDLE) && !done;

   pc_target_calc u_calc (
      .kind       (cap_kind),
      .taken      (cap_taken),
      .imm16      (cap_imm),
      .jaddr26    (cap_jaddr),
      .reg_target (cap_reg),
      .pc         (pc),
      .target     (calc_target),
      .misalign   (calc_misalign),
      .redirect   (calc_redirect)
   );

   // The PC cannot move between acceptance and commit, so the CALC stage sees the same old PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         pc           <= RESET_PC;
         done         <= 1'b0;
         redirect     <= 1'b0;
         misalign_err <= 1'b0;
         cap_kind     <= KIND_SEQ;
         cap_taken    <= 1'b0;
         cap_imm      <= '0;
         cap_jaddr    <= '0;
         cap_reg      <= '0;
         tgt_q        <= '0;
         misalign_q   <= 1'b0;
         redirect_q   <= 1'b0;
`ifdef PC_BRANCH_STATS_EN
         taken_cnt     <= '0;
         not_taken_cnt <= '0;
`endif
      end else begin
         done         <= 1'b0;
         redirect     <= 1'b0;
         misalign_err <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  cap_kind  <= req_kind_e'(req_kind);
                  cap_taken <= branch_taken;
                  cap_imm   <= imm16;
                  cap_jaddr <= jaddr26;
                  cap_reg   <= reg_target;
                  state     <= ST_CALC;
               end
            end
            ST_CALC: begin
               tgt_q      <= calc_target;
               misalign_q <= calc_misalign;
               redirect_q <= calc_redirect;
               state      <= ST_COMMIT;
            end
            ST_COMMIT: begin
               pc           <= tgt_q;
               done         <= 1'b1;
               redirect     <= redirect_q;
               misalign_err <= misalign_q;
`ifdef PC_BRANCH_STATS_EN
               if (cap_kind == KIND_BRANCH) begin
                  if (cap_taken) begin
                     if (taken_cnt != '1)
                        taken_cnt <= taken_cnt + STAT_W'(1);
                  end else begin
                     if (not_taken_cnt != '1)
                        not_taken_cnt <= not_taken_cnt + STAT_W'(1);
                  end
               end
`endif
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
